tdm_demux8: RTL
===============

// Module: tdm_demux8
// PURPOSE
//  - Receive end of an 8-lane time-division bit stream: a serial line whose
//    transmitter steps an 8:1 select through slots 0..7, one bit per slot.
//  - Tracks the slot index and scatters each accepted bit to its lane.
//  - Presents the reassembled lane word with a one-cycle valid strobe.
//  - Detects frame-sync loss and re-hunts.
//  - Sits between the serial link pins/CDC stage and the parallel consumer.
// PARAMETERS
//  LANES   8                 number of TDM slots/lanes per frame (>=2)
//  SEL_W   $clog2(LANES)     slot counter width (derived; do not override)
// PORTS
//  clk          in   1      single clock; all logic on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  din_valid    in   1      din/frame_start qualify this cycle
//  din          in   1      serial data bit for current slot
//  frame_start  in   1      marks the bit as slot 0 (valid only with din_valid)
//  out_data     out  LANES  reassembled word; bit i = slot i
//  out_valid    out  1      1-cycle strobe: out_data updated this cycle
//  slot         out  SEL_W  index of the next expected slot
//  locked       out  1      1 = frame alignment held
//  sync_err     out  1      1-cycle strobe on alignment violation
// BEHAVIOUR
//  - Reset (async assert, sync release) values:
//    out_data=0, out_valid=0, slot=0, locked=0, sync_err=0,
//    shadow=0, state=HUNT.
//  - States and transitions:
//    HUNT: ignore din until din_valid&&frame_start. On that beat:
//      shadow[0]<=din; slot<=1; ->LOCKED.
//    LOCKED, on din_valid beats:
//      a) frame_start && slot!=0: sync_err=1; discard partial frame;
//         treat the beat as slot 0: shadow[0]<=din; slot<=1.
//      b) !frame_start && slot==0: sync_err=1; beat discarded; ->HUNT.
//      c) otherwise: shadow[slot]<=din; slot<=slot+1, wrapping
//         LANES-1 -> 0.
//    din_valid=0: state, slot and shadow hold.
//    Gaps of any length mid-frame are legal.
//  - Completion: a beat accepted at slot==LANES-1 loads
//    out_data<={din,shadow[LANES-2:0]} and sets out_valid=1 on the next
//    cycle (latency 1 clk from last-bit edge).
//    out_data holds until the next completion; out_valid is never >1 cycle.
//  - Outputs: locked=1 iff state==LOCKED (registered). sync_err is a
//    registered 1-cycle pulse. Case (a) keeps locked=1; case (b) clears it.
//  - Simultaneous events: a final-slot beat with frame_start=1 (LANES>1)
//    is case (a): no out_valid, sync_err=1.
//  - Reset mid-frame: partial frame lost; out_data returns to 0.
//  - No backpressure: the consumer samples out_data on out_valid. Frames
//    are back-to-back capable: one out_valid per LANES accepted beats.
// STRUCTURE
//  - Shared package tdm_pkg: LANES_DEFAULT=8; typedef enum {HUNT,LOCKED}
//    tdm_state_e; used also by the transmit-side mux/serializer.
//  - One natural sub-module: tdm_slot_ctr (SEL_W wrap counter with
//    load-to-1 and clear).
//  - Remainder (FSM, shadow, output regs) inline.
// TESTING
//  1. Reset, then 8 valid beats, slot0 with frame_start, bits 1,0,1,1,0,0,1,0
//     -> out_valid 1 clk after 8th beat, out_data=8'h4D, locked=1.
//  2. Same frame with din_valid=0 for 3 cycles between slots 3/4
//     -> identical out_data=8'h4D, out_valid only once.
//  3. frame_start asserted at slot 5 -> sync_err pulse; no out_valid for
//     the broken frame; next 7 beats complete frame; locked stays 1.
//  4. Missing frame_start at slot 0 -> sync_err pulse, locked=0; beats
//     ignored until frame_start; then 8'hFF frame -> out_data=8'hFF.
//  5. Two back-to-back frames 8'hA5 then 8'h3C, din_valid always 1
//     -> out_valid exactly 8 clks apart with those values.
//  6. rst_n low after 4 beats -> out_data=0, slot=0, locked=0
//     immediately (async); recovers on next frame_start.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: receive-side demux and transmit-side serializer.
package tdm_pkg;

    localparam int unsigned LANES_DEFAULT = 8;

    typedef enum logic [0:0] {
        StHunt,
        StLocked
    } tdm_state_e;

endpackage

// File: rtl/tdm_demux8_if.sv
// Serial-in / lane-word-out bundle for the TDM demux; master drives the serial side.
interface tdm_demux8_if #(
    parameter int unsigned Lanes = 8,
    parameter int unsigned SelW  = $clog2(Lanes)
);
    logic             din_valid;
    logic             din;
    logic             frame_start;
    logic [Lanes-1:0] out_data;
    logic             out_valid;
    logic [SelW-1:0]  slot;
    logic             locked;
    logic             sync_err;

    modport master (
        output din_valid, din, frame_start,
        input  out_data, out_valid, slot, locked, sync_err
    );

    modport slave (
        input  din_valid, din, frame_start,
        output out_data, out_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: wraps Lanes-1 -> 0; clear has priority over load-to-1 over increment.
module tdm_slot_ctr #(
    parameter int unsigned Lanes = 8,
    parameter int unsigned SelW  = $clog2(Lanes)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            load1_i,
    input  logic            inc_i,
    output logic [SelW-1:0] slot_o
);
    logic [SelW-1:0] slot_d, slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SelW'(1);
        end else if (inc_i) begin
            slot_d = (slot_q == SelW'(Lanes - 1)) ? '0 : slot_q + SelW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
endmodule

// File: rtl/tdm_demux8.sv
// TDM receive demux: tracks slot alignment, scatters serial bits into a lane word,
// strobes each completed frame and flags frame-sync violations.
module tdm_demux8 import tdm_pkg::*; #(
    parameter int unsigned Lanes = LANES_DEFAULT,
    parameter int unsigned SelW  = $clog2(Lanes)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    tdm_demux8_if.slave  bus
);
    tdm_state_e       state_d, state_q;
    // The final slot bit goes straight into out_data, so shadow holds Lanes-1 bits.
    logic [Lanes-2:0] shadow_d, shadow_q;
    logic [Lanes-1:0] out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;
    logic             sync_err_d, sync_err_q;
    logic             ctr_clr, ctr_load1, ctr_inc;
    logic [SelW-1:0]  slot;

    tdm_slot_ctr #(
        .Lanes (Lanes),
        .SelW  (SelW)
    ) u_slot_ctr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (ctr_clr),
        .load1_i (ctr_load1),
        .inc_i   (ctr_inc),
        .slot_o  (slot)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        ctr_clr     = 1'b0;
        ctr_load1   = 1'b0;
        ctr_inc     = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (bus.frame_start) begin
                        shadow_d[0] = bus.din;
                        ctr_load1   = 1'b1;
                        state_d     = StLocked;
                    end
                end
                StLocked: begin
                    if (bus.frame_start && slot != '0) begin
                        // Early frame start: drop the partial frame, restart at slot 0.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = bus.din;
                        ctr_load1   = 1'b1;
                    end else if (!bus.frame_start && slot == '0) begin
                        sync_err_d = 1'b1;
                        ctr_clr    = 1'b1;
                        state_d    = StHunt;
                    end else begin
                        ctr_inc = 1'b1;
                        if (slot == SelW'(Lanes - 1)) begin
                            out_data_d  = {bus.din, shadow_q};
                            out_valid_d = 1'b1;
                        end else begin
                            shadow_d[slot] = bus.din;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StHunt;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot;
    assign bus.locked    = (state_q == StLocked);
    assign bus.sync_err  = sync_err_q;
endmodule
